layer_out_serializer: RTL and testbench
=======================================

Name: layer_out_serializer

Overview:
- Sits directly downstream of one hidden layer's neuron array (e.g. the numNeuron instances of layer 3).
- Captures the parallel activation outputs when the layer fires its output-valid.
- Streams the captured values one word per cycle as the myinput/myinputValid sequence consumed by every neuron of the next layer.
- Adds frame-last and overrun reporting for the layer controller.

Parameters:
- numNeuron, 10, number of neurons in the producing layer; equals words per frame and numWeight of the next layer.
- dataWidth, 16, width of one activation word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- neuron_out  input  numNeuron*dataWidth  concatenated activations; neuron k occupies bits [k*dataWidth +: dataWidth].
- neuron_outvalid  input  numNeuron  per-neuron output-valid pulses; all bits are expected in the same cycle.
- data_out  output  dataWidth  serialized activation; drives next layer's myinput.
- data_out_valid  output  1  drives next layer's myinputValid.
- data_out_last  output  1  high with the final word (index numNeuron-1) of a frame.
- busy  output  1  high while a frame is buffered or being emitted.
- overrun_err  output  1  sticky; a frame arrived that could not be accepted.
- skew_err  output  1  sticky; neuron_outvalid bits disagreed in a cycle.

Behaviour:
- Reset values: data_out=0, data_out_valid=0, data_out_last=0, busy=0, overrun_err=0, skew_err=0, state=IDLE, count=0, buffer=0.
- Reset applies asynchronously at any point, including mid-frame. The partial frame is discarded and no further words are emitted.
- Load trigger is neuron_outvalid[0]. Other bits are used only for the skew check.
- skew_err sets on any cycle where neuron_outvalid is neither all-0 nor all-1. It clears only on rst.
- State machine has two states: IDLE and SHIFT.
- IDLE:
  - On a clock edge with the trigger high, capture neuron_out into buffer, count<=0, state<=SHIFT, busy<=1.
  - Outputs stay invalid on that edge.
- SHIFT, on each clock edge:
  - data_out<=buffer word[count] and data_out_valid<=1.
  - data_out_last<=(count==numNeuron-1).
  - count<=count+1.
- SHIFT exit when count==numNeuron-1 on an edge:
  - If the trigger is also high on that edge, recapture the buffer, count<=0, stay in SHIFT. The next frame follows with no gap.
  - Otherwise state<=IDLE and busy<=0 on that edge. data_out_valid drops on the following edge.
- Trigger high in SHIFT with count<numNeuron-1: the new frame is dropped, buffer is unchanged, overrun_err<=1 (sticky until rst). The current frame completes normally.
- Latency: trigger sampled at edge T gives word0 valid after edge T+1. Word k is valid after edge T+1+k, and last is valid after edge T+numNeuron.
- Output stream per frame is exactly numNeuron contiguous valid cycles, in neuron index order 0..numNeuron-1.
- There is no backpressure: the consumer must accept one word per cycle.
- data_out holds its last value when data_out_valid=0. Consumers gate on valid only.
- count width is $clog2(numNeuron), with a minimum of 1 bit. count never exceeds numNeuron-1.
- Word select is a direct indexed part-select. No arithmetic is applied to data; words pass bit-exact.
- Must work for numNeuron=1: word0 is emitted with last=1, and back-to-back triggers every cycle are legal with no overrun.

Decomposition:
- The shared package holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - localparam helper for count width.
- No sub-module. The buffer, counter and FSM are small enough for one block.
- This block is instantiated once per layer boundary, between the layer N neuron array and the layer N+1 neuron array.

Test Plan:
- Reset then single frame: numNeuron=10, neuron_out words k=16'h0100+k, outvalid=all-1 for one cycle.
  - Response: 10 consecutive valid cycles, 16'h0100..16'h0109.
  - last high only with 16'h0109; busy falls on the last-word edge; no errors.
- Back-to-back: second frame (16'h0200+k) triggered exactly on the edge where count==9.
  - Response: 20 contiguous valid cycles with no gap.
  - last high on 16'h0109 and 16'h0209; overrun_err=0.
- Overrun: second trigger 3 cycles into the first frame.
  - Response: first frame emitted unchanged (16'h0100..0109), second frame never emitted, overrun_err=1 and stays set.
- Skew: neuron_outvalid=10'b0000000001 for one cycle.
  - Response: frame still captured and emitted via bit 0; skew_err=1 sticky.
- Async reset mid-frame: assert rst between clock edges after word 4.
  - Response: valid, last and busy go 0 immediately without waiting for an edge, and no further words appear.
  - A subsequent frame emits from word0.
- numNeuron=1 variant: trigger on 4 consecutive cycles with words A,B,C,D.
  - Response: A,B,C,D on 4 consecutive valid cycles, each with last=1; overrun_err=0.

Source files
------------

// File: rtl/layer_out_serializer_pkg.sv
// Shared types and helpers for the layer output serializer.
// Imported by the serializer top.
package layer_out_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Word counter width; a one-neuron layer still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel activations and streams them one word per cycle
// to the next layer, with frame-last, busy, overrun and valid-skew reporting.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int numNeuron = 10,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron*dataWidth-1:0] neuron_out,
    input  logic [numNeuron-1:0]           neuron_outvalid,
    output logic [dataWidth-1:0]           data_out,
    output logic                           data_out_valid,
    output logic                           data_out_last,
    output logic                           busy,
    output logic                           overrun_err,
    output logic                           skew_err
);

    localparam int                CNT_W    = cnt_width(numNeuron);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(numNeuron - 1);

    ser_state_t                         state_q, state_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    logic [numNeuron*dataWidth-1:0]     buffer_q, buffer_d;
    logic [dataWidth-1:0]               data_q, data_d;
    logic                               valid_q, valid_d;
    logic                               last_q, last_d;
    logic                               overrun_q, overrun_d;
    logic                               skew_q, skew_d;

    logic trigger;
    logic skew_now;
    logic at_last;

    assign trigger  = neuron_outvalid[0];
    assign skew_now = (neuron_outvalid != '0) && (neuron_outvalid != '1);
    assign at_last  = (count_q == LAST_IDX);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        buffer_d  = buffer_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        overrun_d = overrun_q;
        skew_d    = skew_q | skew_now;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    buffer_d = neuron_out;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                data_d  = buffer_q[int'(count_q)*dataWidth +: dataWidth];
                valid_d = 1'b1;
                last_d  = at_last;
                if (at_last) begin
                    count_d = '0;
                    // A trigger on the final word chains the next frame with no gap.
                    if (trigger) begin
                        buffer_d = neuron_out;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                    if (trigger) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the capture buffer is reset as well, so a post-reset frame never sees stale words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            buffer_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
            skew_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buffer_q  <= buffer_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            skew_q    <= skew_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign data_out_last  = last_q;
    assign busy           = (state_q == SHIFT);
    assign overrun_err    = overrun_q;
    assign skew_err       = skew_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench: a 10-neuron and a 1-neuron serializer checked every cycle
// against a queue-based model, plus literal expectations for the directed scenarios.
module tb_layer_out_serializer;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] w;
        logic          l;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [10*DW-1:0] nout [2];
    logic [9:0]       nv   [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] log0[$];
    logic [16:0] log1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int N = (g == 0) ? 10 : 1;

        logic [DW-1:0] dout;
        logic dval, dlast, dbusy, dovr, dskew;

        layer_out_serializer #(.numNeuron(N), .dataWidth(DW)) dut (
            .clk             (clk),
            .rst             (rst),
            .neuron_out      (nout[g][N*DW-1:0]),
            .neuron_outvalid (nv[g][N-1:0]),
            .data_out        (dout),
            .data_out_valid  (dval),
            .data_out_last   (dlast),
            .busy            (dbusy),
            .overrun_err     (dovr),
            .skew_err        (dskew)
        );

        // Model: a queue of words still owed to the consumer. One word leaves per edge;
        // a trigger is accepted only if nothing remains owed after this edge's word.
        ent_t          sched[$];
        logic [DW-1:0] e_data = '0;
        logic          e_val = 1'b0, e_last = 1'b0, e_busy = 1'b0;
        logic          e_ovr = 1'b0, e_skew = 1'b0;

        always @(posedge clk or posedge rst) begin : model
            ent_t e;
            if (rst) begin
                sched.delete();
                e_data = '0;
                e_val  = 1'b0;
                e_last = 1'b0;
                e_ovr  = 1'b0;
                e_skew = 1'b0;
            end else begin
                if (sched.size() > 0) begin
                    e      = sched.pop_front();
                    e_data = e.w;
                    e_val  = 1'b1;
                    e_last = e.l;
                end else begin
                    e_val  = 1'b0;
                    e_last = 1'b0;
                end
                if (nv[g][0]) begin
                    if (sched.size() == 0) begin
                        for (int k = 0; k < N; k++)
                            sched.push_back('{w: nout[g][k*DW +: DW], l: (k == N - 1)});
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
                if (nv[g][N-1:0] != '0 && nv[g][N-1:0] != {N{1'b1}}) e_skew = 1'b1;
            end
            e_busy = (sched.size() != 0);
        end

        logic [20:0] act, expv;
        assign act  = {dout, dval, dlast, dbusy, dovr, dskew};
        assign expv = {e_data, e_val, e_last, e_busy, e_ovr, e_skew};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare_all();
        check("n10_cycle", 32'(u[0].act), 32'(u[0].expv));
        check("n1_cycle",  32'(u[1].act), 32'(u[1].expv));
        if (u[0].dval === 1'b1) log0.push_back({u[0].dlast, u[0].dout});
        if (u[1].dval === 1'b1) log1.push_back({u[1].dlast, u[1].dout});
    endtask

    // Inputs change only after the falling-edge compare, so each rising edge samples stable values.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load10(input logic [15:0] base);
        for (int k = 0; k < 10; k++) nout[0][k*DW +: DW] = base + 16'(k);
    endtask

    task automatic fire10(input logic [9:0] v);
        nv[0] = v;
        tick();
        nv[0] = '0;
    endtask

    int m;
    int cnt;

    initial begin
        nout[0] = '0; nout[1] = '0;
        nv[0]   = '0; nv[1]   = '0;
        #1 rst = 1'b1;
        ticks(3);
        check("reset_n10", 32'(u[0].act), 32'(0));
        check("reset_n1",  32'(u[1].act), 32'(0));
        rst = 1'b0;
        ticks(2);

        // Single frame with latency pin.
        m = log0.size();
        load10(16'h0100);
        fire10('1);
        tick();
        check("f1_latency", 32'({u[0].dval, u[0].dout}), 32'({1'b1, 16'h0100}));
        ticks(11);
        check("f1_count", 32'(log0.size() - m), 32'(10));
        check("f1_last_word", 32'(log0[m+9]), 32'({1'b1, 16'h0109}));
        cnt = 0;
        for (int i = m; i < log0.size(); i++) if (log0[i][16]) cnt++;
        check("f1_last_count", 32'(cnt), 32'(1));
        check("f1_no_err", 32'({u[0].dovr, u[0].dskew}), 32'(0));

        // Back-to-back: second trigger on the count==9 edge.
        m = log0.size();
        load10(16'h0100);
        fire10('1);
        ticks(9);
        load10(16'h0200);
        fire10('1);
        ticks(12);
        check("b2b_count", 32'(log0.size() - m), 32'(20));
        check("b2b_w9",  32'(log0[m+9]),  32'({1'b1, 16'h0109}));
        check("b2b_w10", 32'(log0[m+10]), 32'({1'b0, 16'h0200}));
        check("b2b_w19", 32'(log0[m+19]), 32'({1'b1, 16'h0209}));
        check("b2b_no_ovr", 32'(u[0].dovr), 32'(0));

        // Overrun: second trigger three edges into the first frame.
        m = log0.size();
        load10(16'h0100);
        fire10('1);
        ticks(2);
        load10(16'h0300);
        fire10('1);
        ticks(14);
        check("ovr_count", 32'(log0.size() - m), 32'(10));
        check("ovr_w0", 32'(log0[m]),   32'({1'b0, 16'h0100}));
        check("ovr_w9", 32'(log0[m+9]), 32'({1'b1, 16'h0109}));
        check("ovr_flag", 32'(u[0].dovr), 32'(1));
        ticks(3);
        check("ovr_sticky", 32'(u[0].dovr), 32'(1));

        // Skew: only bit 0 valid still loads the frame.
        m = log0.size();
        load10(16'h0600);
        fire10(10'b0000000001);
        ticks(12);
        check("skew_count", 32'(log0.size() - m), 32'(10));
        check("skew_w0", 32'(log0[m]), 32'({1'b0, 16'h0600}));
        check("skew_flag", 32'(u[0].dskew), 32'(1));

        // Asynchronous reset after word 4.
        load10(16'h0400);
        fire10('1);
        ticks(5);
        check("ar_w4", 32'({u[0].dval, u[0].dout}), 32'({1'b1, 16'h0404}));
        #1 rst = 1'b1;
        #1;
        check("ar_immediate", 32'({u[0].dval, u[0].dlast, u[0].dbusy, u[0].dovr, u[0].dskew}), 32'(0));
        ticks(2);
        rst = 1'b0;
        m = log0.size();
        ticks(5);
        check("ar_no_words", 32'(log0.size() - m), 32'(0));
        load10(16'h0500);
        fire10('1);
        ticks(12);
        check("ar_next_count", 32'(log0.size() - m), 32'(10));
        check("ar_next_w0", 32'(log0[m]),   32'({1'b0, 16'h0500}));
        check("ar_next_w9", 32'(log0[m+9]), 32'({1'b1, 16'h0509}));

        // One-neuron layer: triggers on four consecutive edges.
        m = log1.size();
        nv[1] = 10'd1;
        nout[1][15:0] = 16'hA001; tick();
        nout[1][15:0] = 16'hB002; tick();
        nout[1][15:0] = 16'hC003; tick();
        nout[1][15:0] = 16'hD004; tick();
        nv[1] = '0;
        ticks(3);
        check("n1_count", 32'(log1.size() - m), 32'(4));
        check("n1_a", 32'(log1[m]),   32'({1'b1, 16'hA001}));
        check("n1_b", 32'(log1[m+1]), 32'({1'b1, 16'hB002}));
        check("n1_c", 32'(log1[m+2]), 32'({1'b1, 16'hC003}));
        check("n1_d", 32'(log1[m+3]), 32'({1'b1, 16'hD004}));
        check("n1_no_ovr", 32'(u[1].dovr), 32'(0));

        // Randomized traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            int r;
            nout[0] = {$urandom, $urandom, $urandom, $urandom, $urandom};
            nout[1] = {$urandom, $urandom, $urandom, $urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r < 2)       nv[0] = '1;
            else if (r == 2) nv[0] = 10'($urandom);
            else             nv[0] = '0;
            nv[1] = {9'd0, 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        nv[0] = '0;
        nv[1] = '0;
        ticks(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
